load_store_unit: RTL
====================

# load_store_unit

Multi-cycle load/store unit between the ALU and the data memory port of the RISC-V core. Takes the ALU result as effective address plus rs2 store data, performs byte-lane alignment and byte enables for SB/SH/SW, and issues one valid/ready memory transaction. It returns sign- or zero-extended load data for LB/LH/LW/LBU/LHU and stalls the core while a transaction is outstanding.

## Interface
- No parameters; address and data are fixed at 32 bits.
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_req_valid  in  1  execute stage presents a memory op
- o_req_ready  out  1  unit idle, can accept; `= (state==IDLE)`
- i_alu_data  in  32  effective address (ALU output)
- i_st_data  in  32  store data (rs2)
- i_we  in  1  1 = store, 0 = load
- i_size  in  2  00 byte, 01 half, 10 word; 11 treated as misaligned
- i_unsigned  in  1  zero-extend load (LBU/LHU); ignored for stores and words
- o_stall  out  1  high whenever state != IDLE
- o_done  out  1  one-cycle pulse: op completed
- o_ld_data  out  32  extended load data; valid with o_done on a load, held otherwise
- o_misaligned  out  1  one-cycle pulse: request rejected
- o_mem_valid  out  1  memory request valid
- i_mem_ready  in  1  memory accepts request
- o_mem_addr  out  32  word address, `{addr[31:2],2'b00}`
- o_mem_we  out  1  write enable
- o_mem_be  out  4  byte enables
- o_mem_wdata  out  32  lane-replicated store data
- i_mem_rvalid  in  1  load response valid
- i_mem_rdata  in  32  load response word

## Operation
- States: IDLE, REQ, WAIT.
- IDLE: accept on `i_req_valid && o_req_ready`; latch addr[1:0], size, unsigned, we.
  - If the access is misaligned (half with addr[0]=1; word with addr[1:0]!=0; size 11), pulse o_misaligned next cycle, stay IDLE, no memory access.
  - Otherwise go to REQ.
- REQ: o_mem_valid=1 and all o_mem_* held stable until i_mem_ready.
  - On ready, a store goes to IDLE with o_done next cycle; a load goes to WAIT.
- WAIT: on i_mem_rvalid, register the extracted data into o_ld_data, pulse o_done, go to IDLE.
  - i_mem_rvalid is ignored in IDLE and REQ. Memory guarantees rvalid at least one cycle after the ready cycle.
- Store lanes:
  - byte: wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0]
  - half: wdata={2{d[15:0]}}, be=4'b0011<<addr[1:0]
  - word: wdata=d, be=4'b1111
- Load extract: `r = rdata >> (8*addr[1:0])`. Byte uses r[7:0] and half uses r[15:0], each sign-extended unless i_unsigned. Word passes through.
- Reset: state=IDLE. o_mem_valid, o_mem_we, o_done, o_misaligned, o_stall = 0. o_mem_be=0, o_mem_addr=0, o_mem_wdata=0, o_ld_data=0. o_req_ready=1 (derived). Reset mid-transaction abandons it; a late rvalid is ignored.

## Timing
- Accept in cycle N → o_mem_valid high in N+1.
- Store with ready in N+1 → o_done in N+2. Minimum store latency is 2 cycles.
- Load with ready in N+1 and rvalid in N+2 → o_done and o_ld_data in N+3. Minimum load latency is 3 cycles.
- Misaligned accept in N → o_misaligned in N+1, o_stall stays 0, and a new request is accepted in N+1.
- o_done and o_misaligned never assert together. Each is high for exactly one cycle.
- Back-to-back: a new accept is possible in the cycle o_done is high, since state is IDLE.

## Structure
- Package lsu_pkg holds:
  - enum lsu_state_e {IDLE, REQ, WAIT}
  - enum lsu_size_e {SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10}
  - constants BE_BYTE=4'b0001, BE_HALF=4'b0011, BE_WORD=4'b1111
- Sub-module lsu_align is purely combinational: store lane/BE generation, load extract/extend, misalignment detect. The FSM and registers stay in load_store_unit.

## Test plan
- SB addr=0x1003, data=0xAABBCC5A, ready immediate → o_mem_addr=0x1000, be=4'b1000, wdata=0x5A5A5A5A, o_done 2 cycles after accept.
- LH addr=0x2002, rdata=0x8001_1234, signed → o_ld_data=0xFFFF8001. Same with i_unsigned=1 → 0x00008001.
- LW addr=0x3001 → o_misaligned pulse next cycle, o_mem_valid never rises, o_stall stays 0.
- SW with i_mem_ready low for 3 cycles → o_mem_* stable and o_stall=1 throughout; o_done one cycle after ready.
- LBU addr=0x11, rdata=0x0000F700, rvalid 4 cycles after ready → o_ld_data=0x000000F7 with o_done; rvalid pulses outside WAIT are ignored.
- i_rst asserted while in WAIT, then a late rvalid → unit IDLE, all outputs at reset values, no o_done.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Imported by the aligner and the load_store_unit top.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } lsu_size_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational byte-lane logic: store lanes and enables,
// misalignment detect, and load extract/extend.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_st_lo,
  input  logic [1:0]  i_st_size,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic        o_misaligned,
  input  logic [1:0]  i_ld_lo,
  input  logic [1:0]  i_ld_size,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_ld_data
);

  logic [31:0] shifted;
  logic        sign_b;
  logic        sign_h;

  always_comb begin
    o_wdata      = i_st_data;
    o_be         = BE_WORD;
    o_misaligned = 1'b1;
    unique case (i_st_size)
      SZ_B: begin
        o_wdata      = {4{i_st_data[7:0]}};
        o_be         = BE_BYTE << i_st_lo;
        o_misaligned = 1'b0;
      end
      SZ_H: begin
        o_wdata      = {2{i_st_data[15:0]}};
        o_be         = BE_HALF << i_st_lo;
        o_misaligned = i_st_lo[0];
      end
      SZ_W: begin
        o_misaligned = |i_st_lo;
      end
      default: begin
        o_misaligned = 1'b1;
      end
    endcase
  end

  // Extension fill bit is zero for unsigned loads.
  always_comb begin
    shifted   = i_rdata >> {i_ld_lo, 3'b000};
    sign_b    = ~i_ld_unsigned & shifted[7];
    sign_h    = ~i_ld_unsigned & shifted[15];
    o_ld_data = shifted;
    unique case (i_ld_size)
      SZ_B:    o_ld_data = {{24{sign_b}}, shifted[7:0]};
      SZ_H:    o_ld_data = {{16{sign_h}}, shifted[15:0]};
      default: o_ld_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: one valid/ready memory
// transaction per op, stalls the core while busy.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_alu_data,
  input  logic [31:0] i_st_data,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_ld_data,
  output logic        o_misaligned,
  output logic        o_mem_valid,
  input  logic        i_mem_ready,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [3:0]  o_mem_be,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  lsu_state_e  state_q, state_d;
  logic [1:0]  lo_q, lo_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ld_q, ld_d;
  logic        done_q, done_d;
  logic        mis_q, mis_d;

  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic        al_mis;
  logic [31:0] al_ld;

  lsu_align u_align (
    .i_st_lo       (i_alu_data[1:0]),
    .i_st_size     (i_size),
    .i_st_data     (i_st_data),
    .o_wdata       (al_wdata),
    .o_be          (al_be),
    .o_misaligned  (al_mis),
    .i_ld_lo       (lo_q),
    .i_ld_size     (size_q),
    .i_ld_unsigned (uns_q),
    .i_rdata       (i_mem_rdata),
    .o_ld_data     (al_ld)
  );

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    ld_d    = ld_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          lo_d   = i_alu_data[1:0];
          size_d = i_size;
          uns_d  = i_unsigned;
          if (al_mis) begin
            mis_d = 1'b1;
          end else begin
            state_d = REQ;
            addr_d  = {i_alu_data[31:2], 2'b00};
            we_d    = i_we;
            be_d    = al_be;
            wdata_d = al_wdata;
          end
        end
      end
      REQ: begin
        if (i_mem_ready) begin
          if (we_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (i_mem_rvalid) begin
          state_d = IDLE;
          ld_d    = al_ld;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      lo_q    <= 2'b00;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      ld_q    <= 32'd0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
    end
  end

  assign o_req_ready  = (state_q == IDLE);
  assign o_stall      = (state_q != IDLE);
  assign o_mem_valid  = (state_q == REQ);
  assign o_mem_addr   = addr_q;
  assign o_mem_we     = we_q;
  assign o_mem_be     = be_q;
  assign o_mem_wdata  = wdata_q;
  assign o_ld_data    = ld_q;
  assign o_done       = done_q;
  assign o_misaligned = mis_q;

endmodule
